l2_switch_fabric: RTL

Parametrised N-port, single-beat-frame Layer-2 switch core that replaces the fixed 4-node switch inside the FPGA switch simulator. Each port has an ingress FIFO. A round-robin forwarding engine learns source addresses into a MAC table and performs destination lookup. It unicasts on a hit, floods on a miss or broadcast, and filters frames whose destination sits on the ingress port. It sits between the node front-ends (keypad/DIP/send-button frame builders) and the LED/LCD receive indicators.

---
 rtl/l2_switch_pkg.sv | 34 +++
 rtl/l2_switch_fabric_if.sv | 28 ++
 rtl/l2_mac_table.sv | 79 +++++++
 rtl/l2_switch_fabric.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/l2_switch_pkg.sv
// Shared definitions for the L2 switch fabric.
// Contents: frame field offset helpers, broadcast address, engine state
// encoding, node address constants and a saturating counter helper.
package l2_switch_pkg;

  // Frames are {dst, src, payload} with dst in the MSBs.
  function automatic int unsigned dst_lsb(int unsigned addr_w, int unsigned payload_w);
    return addr_w + payload_w;
  endfunction

  function automatic int unsigned src_lsb(int unsigned payload_w);
    return payload_w;
  endfunction

  // All-ones at the widest supported address; slice to the address width in use.
  localparam int unsigned MaxAddrW = 16;
  localparam logic [MaxAddrW-1:0] BCAST_ADDR = '1;

  localparam logic [3:0] NODE_A = 4'hA;
  localparam logic [3:0] NODE_B = 4'hB;
  localparam logic [3:0] NODE_C = 4'hC;
  localparam logic [3:0] NODE_D = 4'hD;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StDeliver
  } engine_state_e;

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/l2_switch_fabric_if.sv
// Port bundle of the L2 switch fabric.
// Ingress: in_valid/in_ready/in_frame per port. Egress: out_valid/out_ready/
// out_frame per port. Event counters: fwd_cnt, flood_cnt, drop_cnt.
// slave = switch side, master = node front-end / receive indicator side.
interface l2_switch_fabric_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned FRAME_W   = 12
);
  logic [NUM_PORTS-1:0]         in_valid;
  logic [NUM_PORTS-1:0]         in_ready;
  logic [NUM_PORTS*FRAME_W-1:0] in_frame;
  logic [NUM_PORTS-1:0]         out_valid;
  logic [NUM_PORTS-1:0]         out_ready;
  logic [NUM_PORTS*FRAME_W-1:0] out_frame;
  logic [15:0]                  fwd_cnt;
  logic [15:0]                  flood_cnt;
  logic [15:0]                  drop_cnt;

  modport master (
    output in_valid, in_frame, out_ready,
    input  in_ready, out_valid, out_frame, fwd_cnt, flood_cnt, drop_cnt
  );

  modport slave (
    input  in_valid, in_frame, out_ready,
    output in_ready, out_valid, out_frame, fwd_cnt, flood_cnt, drop_cnt
  );
endinterface

// File: rtl/l2_mac_table.sv
// MAC address table: parallel destination lookup plus source learning.
// Ports: clk, rst, lookup_addr -> hit/hit_port (combinational, current
// contents), learn_en/learn_addr/learn_port (write at the clock edge).
// Learning: refresh a matching entry, else fill the first free entry, else
// overwrite the victim entry and advance the victim pointer.
module l2_mac_table
  import l2_switch_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned PORT_W      = 2,
  parameter int unsigned TABLE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [PORT_W-1:0] hit_port,
  input  logic              learn_en,
  input  logic [ADDR_W-1:0] learn_addr,
  input  logic [PORT_W-1:0] learn_port
);

  localparam int unsigned VW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;

  logic [TABLE_DEPTH-1:0] valid_q;
  logic [ADDR_W-1:0]      addr_q [TABLE_DEPTH];
  logic [PORT_W-1:0]      port_q [TABLE_DEPTH];
  logic [VW-1:0]          victim_q;

  logic          src_hit, free_found;
  logic [VW-1:0] src_idx, free_idx;

  always_comb begin
    hit        = 1'b0;
    hit_port   = '0;
    src_hit    = 1'b0;
    src_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
      if (!hit && valid_q[i] && addr_q[i] == lookup_addr) begin
        hit      = 1'b1;
        hit_port = port_q[i];
      end
      if (!src_hit && valid_q[i] && addr_q[i] == learn_addr) begin
        src_hit = 1'b1;
        src_idx = VW'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = VW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      victim_q <= '0;
      for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
        addr_q[i] <= '0;
        port_q[i] <= '0;
      end
    end else if (learn_en && learn_addr != BCAST_ADDR[ADDR_W-1:0]) begin
      if (src_hit) begin
        port_q[src_idx] <= learn_port;
      end else if (free_found) begin
        valid_q[free_idx] <= 1'b1;
        addr_q[free_idx]  <= learn_addr;
        port_q[free_idx]  <= learn_port;
      end else begin
        addr_q[victim_q] <= learn_addr;
        port_q[victim_q] <= learn_port;
        victim_q <= (victim_q == VW'(TABLE_DEPTH - 1)) ? '0 : victim_q + VW'(1);
      end
    end
  end

endmodule

// File: rtl/l2_switch_fabric.sv
// N-port single-beat-frame L2 switch core.
// Ports: clk, rst (async, active high), bus (l2_switch_fabric_if.slave):
// per-port ingress valid/ready/frame, egress valid/ready/frame and the
// saturating fwd/flood/drop counters.
// Per-port ingress FIFOs feed a round-robin engine (IDLE -> LOOKUP ->
// DELIVER) that learns sources, looks up destinations and loads the
// egress registers of every target port in one cycle.
module l2_switch_fabric
  import l2_switch_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned PAYLOAD_W   = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TABLE_DEPTH = 4,
  parameter int unsigned FRAME_W     = 2 * ADDR_W + PAYLOAD_W
) (
  input logic               clk,
  input logic               rst,
  l2_switch_fabric_if.slave bus
);

  localparam int unsigned PW     = $clog2(NUM_PORTS);
  localparam int unsigned CW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = CW + 1;
  localparam int unsigned DstLsb = dst_lsb(ADDR_W, PAYLOAD_W);
  localparam int unsigned SrcLsb = src_lsb(PAYLOAD_W);

  logic [NUM_PORTS-1:0] fifo_ready, fifo_nonempty, fifo_pop;
  logic [FRAME_W-1:0]   fifo_head [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
    logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
    logic [CW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    cnt_q;
    logic               push;

    assign push             = bus.in_valid[p] && fifo_ready[p];
    assign fifo_ready[p]    = (cnt_q != CntW'(FIFO_DEPTH));
    assign fifo_nonempty[p] = (cnt_q != '0);
    assign fifo_head[p]     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_frame[p*FRAME_W +: FRAME_W];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + CW'(1);
        if (fifo_pop[p]) rd_ptr_q <= rd_ptr_q + CW'(1);
        if (push && !fifo_pop[p]) cnt_q <= cnt_q + CntW'(1);
        else if (fifo_pop[p] && !push) cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

  engine_state_e                state_q;
  logic [PW-1:0]                rr_q, hold_port_q, grant_port;
  logic [FRAME_W-1:0]           hold_frame_q;
  logic [NUM_PORTS-1:0]         mask_q, mask_d, out_valid_q;
  logic                         flood_q, flood_d, grant_valid, deliver_ok;
  logic [NUM_PORTS*FRAME_W-1:0] out_frame_q;
  logic [15:0]                  fwd_cnt_q, flood_cnt_q, drop_cnt_q;
  logic                         hit;
  logic [PW-1:0]                hit_port;
  logic [ADDR_W-1:0]            dst, src;

  assign dst = hold_frame_q[DstLsb +: ADDR_W];
  assign src = hold_frame_q[SrcLsb +: ADDR_W];

  // Search starts one past the last grant, so each port gets a turn.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_port  = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = (32'(rr_q) + i) % NUM_PORTS;
      if (!grant_valid && fifo_nonempty[PW'(cand)]) begin
        grant_valid = 1'b1;
        grant_port  = PW'(cand);
      end
    end
  end

  always_comb begin
    fifo_pop = '0;
    if (state_q == StIdle && grant_valid) fifo_pop[grant_port] = 1'b1;
  end

  always_comb begin
    mask_d  = '0;
    flood_d = 1'b0;
    if (dst == BCAST_ADDR[ADDR_W-1:0] || !hit) begin
      mask_d              = '1;
      mask_d[hold_port_q] = 1'b0;
      flood_d             = 1'b1;
    end else if (hit_port != hold_port_q) begin
      mask_d[hit_port] = 1'b1;
    end
  end

  // A masked egress slot is usable if empty or being drained this cycle.
  assign deliver_ok = &(~mask_q | ~out_valid_q | bus.out_ready);

  l2_mac_table #(
    .ADDR_W      (ADDR_W),
    .PORT_W      (PW),
    .TABLE_DEPTH (TABLE_DEPTH)
  ) u_mac_table (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (dst),
    .hit         (hit),
    .hit_port    (hit_port),
    .learn_en    (state_q == StLookup),
    .learn_addr  (src),
    .learn_port  (hold_port_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_q         <= PW'(NUM_PORTS - 1);
      hold_frame_q <= '0;
      hold_port_q  <= '0;
      mask_q       <= '0;
      flood_q      <= 1'b0;
      out_valid_q  <= '0;
      out_frame_q  <= '0;
      fwd_cnt_q    <= '0;
      flood_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_q & ~bus.out_ready;
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            hold_frame_q <= fifo_head[grant_port];
            hold_port_q  <= grant_port;
            rr_q         <= grant_port;
            state_q      <= StLookup;
          end
        end
        StLookup: begin
          mask_q  <= mask_d;
          flood_q <= flood_d;
          state_q <= StDeliver;
        end
        StDeliver: begin
          if (mask_q == '0) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
            state_q    <= StIdle;
          end else if (deliver_ok) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
              if (mask_q[p]) begin
                out_valid_q[p]                     <= 1'b1;
                out_frame_q[p*FRAME_W +: FRAME_W] <= hold_frame_q;
              end
            end
            if (flood_q) flood_cnt_q <= sat_inc(flood_cnt_q);
            else         fwd_cnt_q   <= sat_inc(fwd_cnt_q);
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = fifo_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_frame = out_frame_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
  assign bus.flood_cnt = flood_cnt_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule
